// File: rtl/segway_pkg.sv
// Shared constants and types for the Segway control slice: SPI monarch
// timing points and the inertial sequencer's sensor command words.
package segway_pkg;

   localparam int unsigned CMD_W = 16;
   localparam int unsigned DIV_W = 4;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRONT = 2'd1,
      SHIFT = 2'd2,
      BACK  = 2'd3
   } spi_state_t;

   // Divider values: idle preset keeps SCLK high, sample just before SCLK rise,
   // shift on SCLK fall.
   localparam logic [DIV_W-1:0] SCLK_PRESET = 4'b1011;
   localparam logic [DIV_W-1:0] SMPL_PT     = 4'b0111;
   localparam logic [DIV_W-1:0] SHFT_PT     = 4'b1111;
   // Final shift closes the frame one clk before the would-be 17th fall.
   localparam logic [DIV_W-1:0] END_PT      = 4'b1110;
   localparam logic [CNT_W-1:0] LAST_CNT    = 4'd14;

   // Inertial sensor command words used by the sequencer.
   localparam logic [CMD_W-1:0] INERT_CMD_INT_CFG = 16'h0D02;
   localparam logic [CMD_W-1:0] INERT_CMD_ACC_CFG = 16'h1053;
   localparam logic [CMD_W-1:0] INERT_CMD_GYR_CFG = 16'h1150;
   localparam logic [CMD_W-1:0] INERT_CMD_PTCH_L  = 16'hA200;
   localparam logic [CMD_W-1:0] INERT_CMD_PTCH_H  = 16'hA300;

endpackage

// File: rtl/spi_mnrch.sv
// SPI mode-3 monarch: shifts one 16-bit command out on MOSI while capturing
// the 16-bit reply from MISO, SCLK = clk/16.
module spi_mnrch
   import segway_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wrt,
   input  logic [CMD_W-1:0] cmd,
   input  logic             MISO,
   output logic             SS_n,
   output logic             SCLK,
   output logic             MOSI,
   output logic             done,
   output logic [CMD_W-1:0] rd_data
);

   spi_state_t       state, nxt_state;
   logic [DIV_W-1:0] sclk_div;
   logic [CMD_W-1:0] shft_reg;
   logic [CNT_W-1:0] shft_cnt;
   logic             miso_smpl;
   logic             init, smpl, shft, set_done, div_run;

   assign SCLK    = sclk_div[DIV_W-1];
   assign MOSI    = shft_reg[CMD_W-1];
   assign rd_data = shft_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   // Next state and datapath enables.
   always_comb begin
      nxt_state = state;
      init      = 1'b0;
      smpl      = 1'b0;
      shft      = 1'b0;
      set_done  = 1'b0;
      div_run   = 1'b0;
      case (state)
         IDLE: begin
            if (wrt) begin
               init      = 1'b1;
               nxt_state = FRONT;
            end
         end
         FRONT: begin
            div_run = 1'b1;
            if (sclk_div == SHFT_PT) nxt_state = SHIFT;
         end
         SHIFT: begin
            div_run = 1'b1;
            if (sclk_div == SMPL_PT) smpl = 1'b1;
            if (sclk_div == SHFT_PT) begin
               shft = 1'b1;
               if (shft_cnt == LAST_CNT) nxt_state = BACK;
            end
         end
         BACK: begin
            div_run = 1'b1;
            if (sclk_div == SMPL_PT) smpl = 1'b1;
            if (sclk_div == END_PT) begin
               shft      = 1'b1;
               set_done  = 1'b1;
               div_run   = 1'b0;
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                sclk_div <= SCLK_PRESET;
      else if (init || set_done) sclk_div <= SCLK_PRESET;
      else if (div_run)          sclk_div <= sclk_div + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     shft_reg <= '0;
      else if (init)  shft_reg <= cmd;
      else if (shft)  shft_reg <= {shft_reg[CMD_W-2:0], miso_smpl};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     shft_cnt <= '0;
      else if (init)  shft_cnt <= '0;
      else if (shft)  shft_cnt <= shft_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     miso_smpl <= 1'b0;
      else if (smpl)  miso_smpl <= MISO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         SS_n <= 1'b1;
      end else if (init) begin
         done <= 1'b0;
         SS_n <= 1'b0;
      end else if (set_done) begin
         done <= 1'b1;
         SS_n <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_mnrch.sv
// Self-checking bench for spi_mnrch: loopback, constant-one and sensor-model
// replies, ignored wrt, back-to-back commands and mid-frame reset.
module tb_spi_mnrch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wrt;
   logic [15:0] cmd;
   logic        miso;
   logic        ss_n, sclk, mosi, done;
   logic [15:0] rd_data;

   int          n_checks = 0;
   int          n_fail   = 0;

   // 0: loopback, 1: MISO held high, 2: sensor model
   int          mode = 0;
   logic [15:0] sens_resp = 16'h0000;
   int          sens_idx = 0;
   logic        sens_bit = 1'b0;

   logic [15:0] mosi_cap = 16'h0000;
   int          n_rise = 0;
   int          n_fall = 0;

   spi_mnrch dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (wrt),
      .cmd     (cmd),
      .MISO    (miso),
      .SS_n    (ss_n),
      .SCLK    (sclk),
      .MOSI    (mosi),
      .done    (done),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : sens_bit;

   // Sensor: presents bit 15 at select, next bit after each SCLK rise.
   always @(negedge ss_n) begin
      sens_idx = 0;
      sens_bit = sens_resp[15];
   end
   always @(posedge sclk) begin
      if (!ss_n) begin
         sens_idx = sens_idx + 1;
         sens_bit = (sens_idx < 16) ? sens_resp[15-sens_idx] : 1'b0;
         mosi_cap = {mosi_cap[14:0], mosi};
         n_rise   = n_rise + 1;
      end
   end
   always @(negedge sclk) begin
      if (!ss_n) n_fall = n_fall + 1;
   end

   function automatic logic [15:0] exp_rx(input int m, input logic [15:0] c,
                                          input logic [15:0] r);
      if (m == 0)      return c;
      else if (m == 1) return 16'hFFFF;
      else             return r;
   endfunction

   task automatic clear_mon();
      mosi_cap = 16'h0000;
      n_rise   = 0;
      n_fall   = 0;
   endtask

   // Returns one clk past edge 0 with wrt low again.
   task automatic start_txn(input logic [15:0] c);
      clear_mon();
      wrt = 1'b1;
      cmd = c;
      @(posedge clk);
      #1;
      wrt = 1'b0;
      cmd = 16'($urandom);
   endtask

   // Counts edges after edge 0 until done; optional wrt re-pulse at inj_edge.
   task automatic wait_done(input int inj_edge, input logic [15:0] inj_cmd,
                            output int done_edge, output int first_fall);
      logic prev;
      prev       = sclk;
      done_edge  = -1;
      first_fall = -1;
      for (int e = 1; e <= 400; e++) begin
         if (e == inj_edge) begin
            wrt = 1'b1;
            cmd = inj_cmd;
         end
         @(posedge clk);
         #1;
         wrt = 1'b0;
         if (prev && !sclk && first_fall < 0) first_fall = e;
         prev = sclk;
         if (done) begin
            done_edge = e;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wrt   = 1'b0;
      cmd   = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({ss_n, sclk, done, mosi} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_ctrl: SS_n,SCLK,done,MOSI=%b expected 1100", {ss_n, sclk, done, mosi});
      end
      n_checks++;
      if (rd_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
      end
   endtask

   task automatic test_loopback();
      int de, ff;
      mode = 0;
      start_txn(16'hA5C3);
      n_checks++;
      if (ss_n !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_ss_fall: SS_n=%b after edge 0 expected 0", ss_n);
      end
      wait_done(-1, 16'h0000, de, ff);
      n_checks++;
      if (ff != 5) begin
         n_fail++;
         $display("FAIL loop_first_fall: edge %0d expected 5", ff);
      end
      n_checks++;
      if (de != 260) begin
         n_fail++;
         $display("FAIL loop_done_edge: edge %0d expected 260", de);
      end
      n_checks++;
      if (rd_data !== 16'hA5C3 || ss_n !== 1'b1 || sclk !== 1'b1) begin
         n_fail++;
         $display("FAIL loop_data: rd_data=%h SS_n=%b SCLK=%b expected a5c3 1 1", rd_data, ss_n, sclk);
      end
      n_checks++;
      if (n_rise != 16 || n_fall != 16) begin
         n_fail++;
         $display("FAIL loop_sclk_count: rises=%0d falls=%0d expected 16 16", n_rise, n_fall);
      end
   endtask

   task automatic test_miso_high();
      int de, ff;
      mode = 1;
      start_txn(16'h0D02);
      wait_done(-1, 16'h0000, de, ff);
      n_checks++;
      if (rd_data !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL ones_rd_data: got %h expected ffff", rd_data);
      end
      n_checks++;
      if (mosi_cap !== 16'h0D02) begin
         n_fail++;
         $display("FAIL ones_mosi_cap: got %h expected 0d02", mosi_cap);
      end
   endtask

   task automatic test_sensor();
      int de, ff;
      int bad;
      mode      = 2;
      sens_resp = 16'h00C4;
      bad       = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (sclk !== 1'b1) bad++;
      end
      start_txn(16'hA200);
      wait_done(-1, 16'h0000, de, ff);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (sclk !== 1'b1 || ss_n !== 1'b1) bad++;
      end
      n_checks++;
      if (rd_data !== 16'h00C4) begin
         n_fail++;
         $display("FAIL sensor_rd_data: got %h expected 00c4", rd_data);
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL sensor_idle_sclk: %0d idle cycles with SCLK/SS_n low, expected 0", bad);
      end
   endtask

   task automatic test_ignored_wrt();
      int de, ff;
      mode = 0;
      start_txn(16'h1053);
      wait_done(100, 16'hFFFF, de, ff);
      n_checks++;
      if (mosi_cap !== 16'h1053 || rd_data !== 16'h1053) begin
         n_fail++;
         $display("FAIL ignore_wrt_data: mosi_cap=%h rd_data=%h expected 1053 1053", mosi_cap, rd_data);
      end
      n_checks++;
      if (de != 260) begin
         n_fail++;
         $display("FAIL ignore_wrt_done: edge %0d expected 260", de);
      end
   endtask

   task automatic test_back_to_back();
      int de, ff;
      mode = 0;
      start_txn(16'h5AA5);
      wait_done(-1, 16'h0000, de, ff);
      clear_mon();
      wrt = 1'b1;
      cmd = 16'h1150;
      @(posedge clk);
      #1;
      wrt = 1'b0;
      cmd = 16'h0000;
      n_checks++;
      if (done !== 1'b0 || ss_n !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: done=%b SS_n=%b expected 0 0", done, ss_n);
      end
      wait_done(-1, 16'h0000, de, ff);
      n_checks++;
      if (de != 260 || rd_data !== 16'h1150) begin
         n_fail++;
         $display("FAIL b2b_second: edge %0d rd_data=%h expected 260 1150", de, rd_data);
      end
   endtask

   task automatic test_mid_reset();
      int de, ff;
      int partial;
      mode = 0;
      start_txn(16'hC3A5);
      repeat (129) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ss_n, sclk, done} !== 3'b110 || rd_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL midrst_outputs: SS_n,SCLK,done=%b rd_data=%h expected 110 0000", {ss_n, sclk, done}, rd_data);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      partial = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (done || !ss_n) partial++;
      end
      n_checks++;
      if (partial != 0) begin
         n_fail++;
         $display("FAIL midrst_no_done: %0d cycles with done high or SS_n low, expected 0", partial);
      end
      start_txn(16'h3C96);
      wait_done(-1, 16'h0000, de, ff);
      n_checks++;
      if (de != 260 || rd_data !== 16'h3C96) begin
         n_fail++;
         $display("FAIL midrst_fresh: edge %0d rd_data=%h expected 260 3c96", de, rd_data);
      end
   endtask

   task automatic test_random();
      int          de, ff;
      logic [15:0] c, r, ex;
      for (int k = 0; k < 6; k++) begin
         mode      = int'($urandom_range(0, 2));
         c         = 16'($urandom);
         r         = 16'($urandom);
         sens_resp = r;
         ex        = exp_rx(mode, c, r);
         repeat (int'($urandom_range(0, 5))) @(posedge clk);
         #1;
         start_txn(c);
         wait_done(-1, 16'h0000, de, ff);
         n_checks++;
         if (de != 260 || rd_data !== ex || mosi_cap !== c) begin
            n_fail++;
            $display("FAIL rand_%0d: mode %0d edge %0d rd_data=%h mosi=%h expected 260 %h %h",
                     k, mode, de, rd_data, mosi_cap, ex, c);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_miso_high();
      test_sensor();
      test_ignored_wrt();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
